spi_slave_if: RTL and testbench

- SPI slave front end: deserialises MOSI frames into 10-bit words for the single-port memory block, and serialises the memory's 8-bit read data back out on MISO.
- Sits between the external SPI pins (SS_n, MOSI, MISO) and the memory's din/rx_valid/dout/tx_valid interface.
- SPI clock is the system clock clk.
- Tracks read-address/read-data sequencing internally, so the host needs only one command bit per frame.

---
 rtl/spi_slave_if.sv | 165 ++++++++++++++++
 tb/tb_spi_slave_if.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI slave: frames MOSI into DATA_W-bit words (rx_valid one cycle after the last bit) and shifts read data out on MISO.
// No backpressure; build with SPI_TX_TIMEOUT_EN to send all-ones read data when tx_valid never arrives.
module spi_slave_if #(
  parameter int DATA_W     = 10,
  parameter int TX_W       = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [TX_W-1:0]   tx_data,
  input  logic              tx_valid
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int TXC_W = $clog2(TX_W + 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0] shift_q, shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              miso_q, miso_d;
  logic              pend_q, pend_d;
  logic              tx_act_q, tx_act_d;
  logic              tx_done_q, tx_done_d;
  logic [TXC_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [TX_W-1:0]   tx_shift_q, tx_shift_d;
  logic              frame_done, frame_last, tx_wait, tx_timeout;
  logic [TX_W-1:0]   tx_load;

  // bit_cnt saturates at DATA_W once the frame word has been delivered
  assign frame_done = (bit_cnt_q == CNT_W'(DATA_W));
  assign frame_last = (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign tx_wait    = (state_q == READ_DATA) && frame_done && !tx_act_q && !tx_done_q;
  assign tx_load    = tx_valid ? tx_data : '1;

`ifdef SPI_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TX_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  assign tx_timeout = (to_cnt_q == TO_W'(TX_TIMEOUT - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!frame_done) begin
      to_cnt_d = '0;
    end else if (tx_wait && !tx_valid && !tx_timeout) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  assign tx_timeout = 1'b0 && (TX_TIMEOUT > 0);
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    miso_d     = miso_q;
    pend_d     = pend_q;
    tx_act_d   = tx_act_q;
    tx_done_d  = tx_done_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    case (state_q)
      IDLE: begin
        miso_d    = 1'b0;
        bit_cnt_d = '0;
        tx_act_d  = 1'b0;
        tx_done_d = 1'b0;
        if (!SS_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        bit_cnt_d = '0;
        if (!MOSI)       state_d = WRITE;
        else if (pend_q) state_d = READ_DATA;
        else             state_d = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (!frame_done) begin
          shift_d   = {shift_q[DATA_W-3:0], MOSI};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (frame_last) begin
            rx_data_d  = {shift_q, MOSI};
            rx_valid_d = 1'b1;
            if (state_q == READ_ADD) pend_d = 1'b1;
          end
        end else if (tx_act_q) begin
          if (tx_cnt_q == TXC_W'(TX_W)) begin
            miso_d    = 1'b0;
            tx_act_d  = 1'b0;
            tx_done_d = 1'b1;
            pend_d    = 1'b0;
          end else begin
            miso_d     = tx_shift_q[TX_W-1];
            tx_shift_d = tx_shift_q << 1;
            tx_cnt_d   = tx_cnt_q + TXC_W'(1);
          end
        end else if (tx_wait && (tx_valid || tx_timeout)) begin
          miso_d     = tx_load[TX_W-1];
          tx_shift_d = tx_load << 1;
          tx_cnt_d   = TXC_W'(1);
          tx_act_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Deselect overrides everything, including a coincident final bit
    if (state_q != IDLE && SS_n) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      miso_d     = 1'b0;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;
      pend_d     = pend_q;
      tx_act_d   = 1'b0;
      tx_done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      pend_q     <= 1'b0;
      tx_act_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      pend_q     <= pend_d;
      tx_act_q   <= tx_act_d;
      tx_done_q  <= tx_done_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: frame table, hand-written reset/abort/timeout sequences, random frames vs a transaction-level model.
module tb_spi_slave_if;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n, MOSI, MISO, rx_valid, tx_valid;
  logic [9:0] rx_data;
  logic [7:0] tx_data;

  int         n_tests = 0;
  int         n_fail  = 0;
  bit         pend_m;   // model: a read address has been sent and awaits its data frame
  logic [9:0] last_rx;  // model: last completed frame word

  typedef struct {
    bit         cmd;
    logic [9:0] data;
    int         nbits;     // data bits before deselect; 10 = full frame, -1 = deselect on command bit
    int         dly;       // cycles after rx_valid before tx_valid; -1 = never
    logic [7:0] txd;
    bit         exp_rxv;
    bit         exp_shift;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(10), .TX_W(8), .TX_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_update(input bit cmd, input int nbits, input int dly);
    if (nbits == 10 && cmd) begin
      if (!pend_m)       pend_m = 1'b1;
      else if (dly >= 0) pend_m = 1'b0;
    end
  endfunction

  task automatic drive(input bit ss, input bit mosi, input bit txv, input logic [7:0] txd);
    SS_n = ss; MOSI = mosi; tx_valid = txv; tx_data = txd;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input string tag, input bit cmd, input logic [9:0] data, input int nbits,
                           input int dly, input logic [7:0] txd, input bit noise,
                           input bit exp_rxv, input bit exp_shift);
    drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
    chk({tag, " idle rx_valid"}, 32'(rx_valid), 32'd0);
    if (nbits < 0) begin
      drive(1'b1, cmd, 1'b0, 8'h00);
      chk({tag, " cmd-abort rx_valid"}, 32'(rx_valid), 32'd0);
      chk({tag, " cmd-abort rx_data"}, 32'(rx_data), 32'(last_rx));
      return;
    end
    drive(1'b0, cmd, noise & 1'($urandom_range(0, 1)), 8'($urandom));
    for (int i = 0; i < nbits; i++) begin
      drive(1'b0, data[9-i], noise & 1'($urandom_range(0, 1)), 8'($urandom));
      chk($sformatf("%s bit%0d rx_valid", tag, i), 32'(rx_valid), 32'((i == 9) && exp_rxv));
      chk($sformatf("%s bit%0d MISO", tag, i), 32'(MISO), 32'd0);
      if (i == 9) chk({tag, " rx_data"}, 32'(rx_data), 32'(data));
    end
    if (nbits < 10) begin
      drive(1'b1, data[9-nbits], 1'b0, 8'h00);
      chk({tag, " abort rx_valid"}, 32'(rx_valid), 32'd0);
      chk({tag, " abort MISO"}, 32'(MISO), 32'd0);
      chk({tag, " abort rx_data hold"}, 32'(rx_data), 32'(last_rx));
      return;
    end
    last_rx = data;
    if (dly >= 0) begin
      for (int d = 0; d < dly; d++) begin
        drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
        chk({tag, " wait rx_valid"}, 32'(rx_valid), 32'd0);
        chk({tag, " wait MISO"}, 32'(MISO), 32'd0);
      end
      drive(1'b0, 1'($urandom_range(0, 1)), 1'b1, txd);
      for (int b = 7; b >= 0; b--) begin
        chk($sformatf("%s MISO bit%0d", tag, b), 32'(MISO), 32'(exp_shift & txd[b]));
        chk({tag, " shift rx_valid"}, 32'(rx_valid), 32'd0);
        drive(1'b0, 1'($urandom_range(0, 1)), noise & 1'($urandom_range(0, 1)), 8'($urandom));
      end
      chk({tag, " MISO after last"}, 32'(MISO), 32'd0);
    end else begin
      for (int k = 0; k < 30; k++) begin
        drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
        chk({tag, " idle-wait MISO"}, 32'(MISO), 32'd0);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    chk({tag, " end MISO"}, 32'(MISO), 32'd0);
    chk({tag, " end rx_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, " end rx_data hold"}, 32'(rx_data), 32'(data));
  endtask

  initial begin
    bit         c;
    logic [9:0] d;
    int         nb, dl, r;
    logic [7:0] t, tv;
    bit         nz;

    vecs[0]  = '{1'b0, 10'h0A5, 10,  1, 8'hAA, 1'b1, 1'b0};  // write, stray tx_valid ignored
    vecs[1]  = '{1'b1, 10'h203, 10,  1, 8'h77, 1'b1, 1'b0};  // read address
    vecs[2]  = '{1'b1, 10'h300, 10,  1, 8'h5C, 1'b1, 1'b1};  // read data, nominal latency
    vecs[3]  = '{1'b1, 10'h011, 10,  1, 8'h3C, 1'b1, 1'b0};  // back to read address
    vecs[4]  = '{1'b1, 10'h0F0, 10,  3, 8'hA5, 1'b1, 1'b1};  // read data, late tx_valid
    vecs[5]  = '{1'b0, 10'h155,  5, -1, 8'h00, 1'b0, 1'b0};  // abort after 5 bits
    vecs[6]  = '{1'b0, 10'h155, 10, -1, 8'h00, 1'b1, 1'b0};  // full write after abort
    vecs[7]  = '{1'b0, 10'h2AA,  9, -1, 8'h00, 1'b0, 1'b0};  // deselect with final bit
    vecs[8]  = '{1'b1, 10'h1FF, 10,  1, 8'h12, 1'b1, 1'b0};  // read address
    vecs[9]  = '{1'b1, 10'h000,  4, -1, 8'h00, 1'b0, 1'b0};  // aborted read keeps pending
    vecs[10] = '{1'b1, 10'h3FF, 10,  2, 8'hC3, 1'b1, 1'b1};  // so this is read data
    vecs[11] = '{1'b0, 10'h000, -1, -1, 8'h00, 1'b0, 1'b0};  // deselect on command bit

    // Reset with active-looking inputs: reset must win
    rst_n = 1'b0; SS_n = 1'b0; MOSI = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset MISO", 32'(MISO), 32'd0);
    chk("reset rx_valid", 32'(rx_valid), 32'd0);
    chk("reset rx_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;
    pend_m = 1'b0; last_rx = 10'h000;
    drive(1'b1, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 12; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].data, vecs[i].nbits, vecs[i].dly,
                vecs[i].txd, 1'b0, vecs[i].exp_rxv, vecs[i].exp_shift);
      model_update(vecs[i].cmd, vecs[i].nbits, vecs[i].dly);
    end

    // Reset in the middle of a read-data shift-out
    run_frame("rst-ra", 1'b1, 10'h203, 10, 1, 8'h00, 1'b0, 1'b1, 1'b0);
    model_update(1'b1, 10, 1);
    d = 10'h300; tv = 8'h5C;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) drive(1'b0, d[9-i], 1'b0, 8'h00);
    chk("rst-rd rx_valid", 32'(rx_valid), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, tv);
    for (int b = 7; b >= 4; b--) begin
      chk($sformatf("rst-rd MISO bit%0d", b), 32'(MISO), 32'(tv[b]));
      drive(1'b0, 1'b0, 1'b0, 8'h00);
    end
    chk("rst-rd MISO bit3", 32'(MISO), 32'(tv[3]));
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 8'hFF);
    rst_n = 1'b1;
    chk("rst-rd MISO", 32'(MISO), 32'd0);
    chk("rst-rd rx_data", 32'(rx_data), 32'd0);
    pend_m = 1'b0; last_rx = 10'h000;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    run_frame("post-rst", 1'b1, 10'h0AB, 10, 1, 8'hFF, 1'b0, 1'b1, 1'b0);
    model_update(1'b1, 10, 1);
    run_frame("post-rst-rd", 1'b1, 10'h111, 10, 2, 8'h81, 1'b0, 1'b1, 1'b1);
    model_update(1'b1, 10, 2);

`ifdef SPI_TX_TIMEOUT_EN
    run_frame("to-ra", 1'b1, 10'h040, 10, 1, 8'h00, 1'b0, 1'b1, 1'b0);
    model_update(1'b1, 10, 1);
    d = 10'h080;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) drive(1'b0, d[9-i], 1'b0, 8'h00);
    chk("to rx_valid", 32'(rx_valid), 32'd1);
    for (int k = 1; k <= 15; k++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      chk($sformatf("to wait%0d MISO", k), 32'(MISO), 32'd0);
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      chk($sformatf("to ones%0d MISO", k), 32'(MISO), 32'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("to after MISO", 32'(MISO), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    pend_m = 1'b0; last_rx = d;
    run_frame("to-next-ra", 1'b1, 10'h0C0, 10, 1, 8'h96, 1'b0, 1'b1, 1'b0);
    model_update(1'b1, 10, 1);
`else
    run_frame("nt-ra", 1'b1, 10'h040, 10, 1, 8'h00, 1'b0, 1'b1, 1'b0);
    model_update(1'b1, 10, 1);
    run_frame("nt-rd-wait", 1'b1, 10'h080, 10, -1, 8'h00, 1'b0, 1'b1, 1'b0);
    model_update(1'b1, 10, -1);
    run_frame("nt-rd", 1'b1, 10'h0C0, 10, 1, 8'h96, 1'b0, 1'b1, 1'b1);
    model_update(1'b1, 10, 1);
`endif

    for (int n = 0; n < 40; n++) begin
      c  = 1'($urandom_range(0, 1));
      d  = 10'($urandom);
      t  = 8'($urandom);
      dl = $urandom_range(1, 5);
      nz = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      nb = (r < 7) ? 10 : ((r == 7) ? -1 : $urandom_range(0, 9));
      run_frame($sformatf("rnd%0d", n), c, d, nb, dl, t, nz, nb == 10, (nb == 10) && c && pend_m);
      model_update(c, nb, dl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1);
  end
endmodule
